// File: rtl/nios_ii_core_pio_in.sv
// Input-direction PIO slave: synchronises external pins, exposes them as DATA,
// latches selected edges into EDGECAP and raises a maskable interrupt.
// Register map: 0 DATA (RO), 1 reserved, 2 IRQMASK (RW), 3 EDGECAP (R/W1C).
module nios_ii_core_pio_in #(
  parameter int WIDTH     = 2,  // number of input pins, 1..32
  parameter int EDGE_TYPE = 0,  // 0 rising, 1 falling, 2 any
  parameter int IRQ_TYPE  = 1   // 0 level from DATA, 1 from EDGECAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edgecap;

  logic             w_wr;
  logic [WIDTH-1:0] w_detect;
  logic [WIDTH-1:0] w_clear;

  // Bits of writedata above WIDTH carry nothing for this block.
  generate
    if (WIDTH < 32) begin : g_wd_hi
      logic w_unused_wd_hi;
      assign w_unused_wd_hi = ^writedata[31:WIDTH];
    end
  endgenerate

  assign w_wr = chipselect & ~write_n;

  // Per-bit edge detect between the synchronised sample and its predecessor.
  always_comb begin
    w_detect = '0;
    if (EDGE_TYPE == 0) begin
      w_detect = r_sync2 & ~r_prev;
    end else if (EDGE_TYPE == 1) begin
      w_detect = ~r_sync2 & r_prev;
    end else begin
      w_detect = r_sync2 ^ r_prev;
    end
  end

  // Write-1-to-clear mask for EDGECAP; only active on a write to address 3.
  always_comb begin
    w_clear = '0;
    if (w_wr && (address == 2'd3)) begin
      w_clear = writedata[WIDTH-1:0];
    end
  end

  // Two-flop synchroniser plus the previous-sample flop used by edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // IRQMASK register, loaded by a write to address 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '0;
    end else if (w_wr && (address == 2'd2)) begin
      r_mask <= writedata[WIDTH-1:0];
    end
  end

  // EDGECAP: a detect in the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edgecap <= '0;
    end else begin
      r_edgecap <= (r_edgecap & ~w_clear) | w_detect;
    end
  end

  // Read mux, zero-extended; deliberately not gated by chipselect.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = r_sync2;
      2'd2:    readdata[WIDTH-1:0] = r_mask;
      2'd3:    readdata[WIDTH-1:0] = r_edgecap;
      default: readdata = '0;
    endcase
  end

  // Interrupt source selected at elaboration time.
  always_comb begin
    if (IRQ_TYPE == 1) begin
      irq = |(r_edgecap & r_mask);
    end else begin
      irq = |(r_sync2 & r_mask);
    end
  end

endmodule
